// File: rtl/rvc_dmem_ctrl.sv
// Word-organised data memory for the rvc_asap cores.
// Byte/half/word loads and stores, misaligned accesses split over two cycles.
module rvc_dmem_ctrl #(
    parameter logic [31:0] DMEM_BASE  = 32'h0001_0000,
    parameter int          DMEM_WORDS = 4096,
    parameter int          ADDR_W     = 32
) (
    input  logic              Clock,
    input  logic              Rst,
    input  logic              Req,
    output logic              ReqReady,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       WrData,
    input  logic [3:0]        ByteEn,
    input  logic              SignExt,
    output logic              RspValid,
    output logic [31:0]       RdData,
    output logic              AccessFault
);

    localparam int IW = $clog2(DMEM_WORDS);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(DMEM_BASE);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(4 * DMEM_WORDS);

    typedef enum logic {
        IDLE,
        SPLIT
    } state_t;

    state_t state, state_d;

    logic [31:0] mem [DMEM_WORDS];

    logic [ADDR_W-1:0] off;
    logic [1:0]        lane;
    logic [IW-1:0]     w0;
    logic [2:0]        sz;
    logic              legal;
    logic              fault;
    logic              mis;
    logic              accept;
    logic [63:0]       wwin;
    logic [7:0]        bwin;

    logic [1:0]    lane_q;
    logic [2:0]    sz_q;
    logic          sext_q;
    logic          wren_q;
    logic [IW-1:0] w1_q;
    logic [31:0]   whi_q;
    logic [3:0]    bhi_q;
    logic [31:0]   lo_q;

    logic [IW-1:0] idx;
    logic [31:0]   wd;
    logic [3:0]    wbe;
    logic [31:0]   rword;

    logic        rsp_d;
    logic [31:0] rdata_d;
    logic        fault_d;

    function automatic logic [31:0] fmt(
        input logic [63:0] win,
        input logic [1:0]  ln,
        input logic [2:0]  n,
        input logic        sx
    );
        logic [31:0] v;
        v = 32'(win >> {ln, 3'b000});
        case (n)
            3'd1:    return {{24{sx & v[7]}}, v[7:0]};
            3'd2:    return {{16{sx & v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    assign off    = Addr - BASE;
    assign lane   = off[1:0];
    assign w0     = off[IW+1:2];
    assign accept = Req & ReqReady;

    assign ReqReady = (state == IDLE) & ~Rst;

    always_comb begin
        sz    = 3'd0;
        legal = 1'b1;
        case (ByteEn)
            4'b0001: sz = 3'd1;
            4'b0011: sz = 3'd2;
            4'b1111: sz = 3'd4;
            default: legal = 1'b0;
        endcase
    end

    // Range check is done one bit wider so the end address cannot wrap.
    assign fault = ~legal | (Addr < BASE)
                 | (({1'b0, off} + (ADDR_W+1)'(sz)) > LIMIT);
    assign mis   = ({1'b0, lane} + sz) > 3'd4;

    // Two-word window: bytes 0..3 land in W0, bytes 4..7 in W0+1.
    assign wwin = {32'b0, WrData} << {lane, 3'b000};
    assign bwin = {4'b0, ByteEn} << lane;

    always_comb begin
        idx = w0;
        wd  = wwin[31:0];
        wbe = bwin[3:0] & {4{accept & WrEn & ~fault}};
        if (state == SPLIT) begin
            idx = w1_q;
            wd  = whi_q;
            wbe = bhi_q & {4{wren_q & ~Rst}};
        end
    end

    assign rword = mem[idx];

    always_ff @(posedge Clock) begin
        for (int b = 0; b < 4; b++) begin
            if (wbe[b]) begin
                mem[idx][8*b +: 8] <= wd[8*b +: 8];
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (accept) begin
            lane_q <= lane;
            sz_q   <= sz;
            sext_q <= SignExt;
            wren_q <= WrEn;
            w1_q   <= w0 + IW'(1);
            whi_q  <= wwin[63:32];
            bhi_q  <= bwin[7:4];
            lo_q   <= rword;
        end
    end

    always_comb begin
        state_d = state;
        rsp_d   = 1'b0;
        rdata_d = RdData;
        fault_d = AccessFault;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (fault | ~mis) begin
                        rsp_d   = 1'b1;
                        fault_d = fault;
                        rdata_d = (fault | WrEn) ? 32'd0
                                : fmt({32'd0, rword}, lane, sz, SignExt);
                    end else begin
                        state_d = SPLIT;
                    end
                end
            end
            SPLIT: begin
                state_d = IDLE;
                rsp_d   = 1'b1;
                fault_d = 1'b0;
                rdata_d = wren_q ? 32'd0
                        : fmt({rword, lo_q}, lane_q, sz_q, sext_q);
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            state       <= IDLE;
            RspValid    <= 1'b0;
            RdData      <= 32'd0;
            AccessFault <= 1'b0;
        end else begin
            state       <= state_d;
            RspValid    <= rsp_d;
            RdData      <= rdata_d;
            AccessFault <= fault_d;
        end
    end

endmodule

// File: tb/tb_rvc_dmem_ctrl.sv
// Scoreboard bench for rvc_dmem_ctrl against a byte-array reference model.
// Expected responses are queued at accept and checked by a separate monitor.
module tb_rvc_dmem_ctrl;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam int W = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        wren;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        rdy;
    logic        rsp;
    logic        flt;
    logic [31:0] rd;

    rvc_dmem_ctrl #(
        .DMEM_BASE(BASE),
        .DMEM_WORDS(W),
        .ADDR_W(32)
    ) dut (
        .Clock(clk),
        .Rst(rst),
        .Req(req),
        .ReqReady(rdy),
        .WrEn(wren),
        .Addr(addr),
        .WrData(wdata),
        .ByteEn(be),
        .SignExt(sx),
        .RspValid(rsp),
        .RdData(rd),
        .AccessFault(flt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        f;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    logic [7:0] mb [0:4*W-1];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int split_cyc = -10;
    int accepts = 0;
    int rsps = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (rdy !== (!rst && cyc != split_cyc)) begin
                errors++;
                $display("FAIL ready cyc=%0d got=%b", cyc, rdy);
            end
            if (rsp === 1'b1) begin
                rsps++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected cyc=%0d d=%h", cyc, rd);
                end else begin
                    mon_e = q.pop_front();
                    if (rd !== mon_e.d || flt !== mon_e.f
                        || cyc != mon_e.cyc) begin
                        errors++;
                        $display("FAIL rsp got d=%h f=%b c=%0d want d=%h f=%b c=%0d",
                                 rd, flt, cyc, mon_e.d, mon_e.f, mon_e.cyc);
                    end
                end
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] g,
                       input logic [31:0] w);
        checks++;
        if (g !== w) begin
            errors++;
            $display("FAIL %s got=%h want=%h", n, g, w);
        end
    endtask

    task automatic model(input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b,
                         input logic s, output logic [31:0] ed,
                         output logic ef, output int lat,
                         output bit split);
        int n;
        longint off;
        logic [31:0] v;
        case (b)
            4'b0001: n = 1;
            4'b0011: n = 2;
            4'b1111: n = 4;
            default: n = 0;
        endcase
        off = longint'(a) - longint'(BASE);
        ef = (n == 0) || (a < BASE) || (off + n > 4 * W);
        ed = 32'd0;
        lat = 1;
        split = 1'b0;
        if (!ef) begin
            split = (off % 4) + n > 4;
            lat = split ? 2 : 1;
            if (w) begin
                for (int k = 0; k < n; k++) mb[int'(off) + k] = d[8*k +: 8];
            end else begin
                v = 32'd0;
                for (int k = 0; k < n; k++) v[8*k +: 8] = mb[int'(off) + k];
                if (s && n < 4 && v[8*n-1]) begin
                    for (int k = 8 * n; k < 32; k++) v[k] = 1'b1;
                end
                ed = v;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_op(input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b,
                         input logic s, input bit ue,
                         input logic [31:0] ev, input logic ef);
        int n;
        exp_t e;
        logic [31:0] md;
        logic mf;
        int lat;
        bit split;
        req = 1'b1;
        wren = w;
        addr = a;
        wdata = d;
        be = b;
        sx = s;
        n = 0;
        @(negedge clk);
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout addr=%h got=%b want=1", a, rdy);
            req = 1'b0;
            return;
        end
        model(w, a, d, b, s, md, mf, lat, split);
        e.d = ue ? ev : md;
        e.f = ue ? ef : mf;
        e.cyc = cyc + lat;
        q.push_back(e);
        if (split) split_cyc = cyc + 1;
        accepts++;
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    int r;
    logic [31:0] a;
    logic [3:0] b;

    initial begin
        rst = 1'b1;
        req = 1'b0;
        wren = 1'b0;
        sx = 1'b0;
        addr = 32'd0;
        wdata = 32'd0;
        be = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rspvalid", 32'(rsp), 32'd0);
        chk("reset_rddata", rd, 32'd0);
        chk("reset_fault", 32'(flt), 32'd0);
        chk("reset_ready", 32'(rdy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < W; i++)
            do_op(1, BASE + 32'(4 * i), $urandom, 4'hF, 0, 0, 0, 0);

        do_op(1, BASE + 8, 32'hDEADBEEF, 4'hF, 0, 1, 32'd0, 0);
        do_op(0, BASE + 8, 32'd0, 4'hF, 0, 1, 32'hDEADBEEF, 0);

        do_op(1, BASE + 0, 32'h11223344, 4'hF, 0, 1, 32'd0, 0);
        do_op(1, BASE + 4, 32'h55667788, 4'hF, 0, 1, 32'd0, 0);
        do_op(0, BASE + 2, 32'd0, 4'hF, 0, 1, 32'h77881122, 0);

        do_op(1, BASE + 5, 32'h80, 4'h1, 0, 1, 32'd0, 0);
        do_op(0, BASE + 5, 32'd0, 4'h1, 1, 1, 32'hFFFFFF80, 0);
        do_op(0, BASE + 5, 32'd0, 4'h1, 0, 1, 32'h00000080, 0);
        do_op(1, BASE + 7, 32'hABCD, 4'h3, 0, 1, 32'd0, 0);
        do_op(0, BASE + 7, 32'd0, 4'h3, 1, 1, 32'hFFFFABCD, 0);

        do_op(0, BASE - 4, 32'd0, 4'hF, 0, 1, 32'd0, 1);
        do_op(1, BASE + 4 * W - 2, 32'h99999999, 4'hF, 0, 1, 32'd0, 1);
        do_op(1, BASE + 0, 32'h99999999, 4'b0101, 0, 1, 32'd0, 1);
        do_op(0, BASE + 4 * W - 4, 32'd0, 4'hF, 0, 0, 0, 0);
        do_op(0, BASE + 0, 32'd0, 4'hF, 0, 0, 0, 0);
        idle(3);

        req = 1'b1;
        wren = 1'b1;
        addr = BASE + 3;
        wdata = 32'hCAFEF00D;
        be = 4'hF;
        sx = 1'b0;
        @(negedge clk);
        chk("t5_accept", 32'(rdy), 32'd1);
        mb[3] = 8'h0D;
        split_cyc = cyc + 1;
        @(posedge clk);
        #1;
        req = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
        do_op(0, BASE + 3, 32'd0, 4'h1, 0, 1, 32'h0000000D, 0);
        do_op(0, BASE + 4, 32'd0, 4'hF, 0, 0, 0, 0);

        for (int i = 0; i < 1000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 5) a = BASE - $urandom_range(1, 8);
            else if (r < 10) a = BASE + 32'(4 * W) - $urandom_range(0, 4);
            else a = BASE + $urandom_range(0, 4 * W - 1);
            r = int'($urandom_range(0, 15));
            if (r < 5) b = 4'b0001;
            else if (r < 10) b = 4'b0011;
            else if (r < 15) b = 4'b1111;
            else b = 4'($urandom_range(0, 15));
            do_op(1'($urandom_range(0, 1)), a, $urandom, b,
                  1'($urandom_range(0, 1)), 0, 0, 0);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end

        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("rsp_count", 32'(rsps), 32'(accepts));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
